// File: rtl/led_pwm_fader_if.sv
// rtl/led_pwm_fader_if.sv - sequencer pattern in / LED pin drive out bundle for the PWM fader
interface led_pwm_fader_if;
   logic [2:0] leds_in;
   logic       fade_en;
   logic [2:0] leds_out;
   logic       busy;

   modport master (output leds_in, output fade_en, input leds_out, input busy);
   modport slave  (input leds_in, input fade_en, output leds_out, output busy);
endinterface

// File: rtl/led_pwm_fader.sv
// rtl/led_pwm_fader.sv - per-channel PWM LED driver with linear brightness ramping
// Active-low pattern in, active-low PWM out; duty ramps one step per STEP_CYCLES cycles.
module led_pwm_fader #(
   parameter int PWM_BITS    = 8,
   parameter int STEP_CYCLES = 60_000
) (
   input  logic           sysclk,
   input  logic           rst,
   led_pwm_fader_if.slave bus
);
   localparam int SC_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [PWM_BITS-1:0] MAX       = '1;
   localparam logic [SC_W-1:0]     STEP_LAST = SC_W'(STEP_CYCLES - 1);

   logic [2:0]          in_q;
   logic [SC_W-1:0]     step_cnt_q, step_cnt_d;
   logic                step_tick;
   logic [PWM_BITS-1:0] pwm_cnt_q;
   logic [PWM_BITS-1:0] tgt       [3];
   logic [PWM_BITS-1:0] duty_q    [3];
   logic [PWM_BITS-1:0] duty_d    [3];
   logic [PWM_BITS-1:0] duty_sh_q [3];
   logic [PWM_BITS-1:0] duty_sh_d [3];
   logic [2:0]          leds_out_q, leds_out_d;
   logic                busy_w;

   always_comb begin
      step_tick  = (step_cnt_q == STEP_LAST);
      step_cnt_d = step_tick ? '0 : step_cnt_q + 1'b1;
      busy_w     = 1'b0;
      leds_out_d = 3'b111;
      for (int i = 0; i < 3; i++) begin
         tgt[i]    = in_q[i] ? '0 : MAX;
         duty_d[i] = duty_q[i];
         if (!bus.fade_en) begin
            duty_d[i] = tgt[i];
         end else if (step_tick) begin
            // Moving only toward the target keeps duty inside 0..MAX without saturation logic.
            if (duty_q[i] < tgt[i]) begin
               duty_d[i] = duty_q[i] + 1'b1;
            end else if (duty_q[i] > tgt[i]) begin
               duty_d[i] = duty_q[i] - 1'b1;
            end
         end
         duty_sh_d[i]  = (pwm_cnt_q == MAX) ? duty_q[i] : duty_sh_q[i];
         leds_out_d[i] = ~(pwm_cnt_q < duty_sh_q[i]);
         busy_w        = busy_w | (duty_q[i] != tgt[i]);
      end
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         in_q       <= 3'b111;
         step_cnt_q <= '0;
         pwm_cnt_q  <= '0;
         leds_out_q <= 3'b111;
         for (int i = 0; i < 3; i++) begin
            duty_q[i]    <= '0;
            duty_sh_q[i] <= '0;
         end
      end else begin
         in_q       <= bus.leds_in;
         step_cnt_q <= step_cnt_d;
         pwm_cnt_q  <= pwm_cnt_q + 1'b1;
         leds_out_q <= leds_out_d;
         for (int i = 0; i < 3; i++) begin
            duty_q[i]    <= duty_d[i];
            duty_sh_q[i] <= duty_sh_d[i];
         end
      end
   end

   assign bus.leds_out = leds_out_q;
   assign bus.busy     = busy_w;
endmodule

// File: doc/led_pwm_fader.md
# led_pwm_fader

Downstream output stage for the RGB LED sequencer. It takes the sequencer's 3-bit active-low on/off pattern and drives the board LED pins with per-channel PWM. Each channel's brightness ramps linearly toward its new target instead of switching hard. The block sits between the sequencer's `leds` output and the top-level LED pins.

## Interface
- `PWM_BITS`, default 8: PWM counter and duty width. MAX = 2^PWM_BITS−1.
- `STEP_CYCLES`, default 60_000: `sysclk` cycles per duty step of ±1. Must be ≥1. The step counter is $clog2(STEP_CYCLES) bits wide, minimum 1.
- `sysclk` in, 1 bit: system clock, the only clock. All logic is on its rising edge.
- `rst` in, 1 bit: synchronous, active-high reset.
- `leds_in` in, 3 bits: target pattern from the sequencer. Active-low: 0 = channel on.
- `fade_en` in, 1 bit: 1 = ramp duty gradually; 0 = snap duty to target.
- `leds_out` out, 3 bits: PWM LED drive, registered. Active-low.
- `busy` out, 1 bit: high while any channel's duty ≠ its target.

## Operation
- `in_q[2:0]`: `leds_in` registered once. Reset value 3'b111.
- Per-channel target: `tgt[i]` = `in_q[i]` ? 0 : MAX.
- `step_cnt`:
  - Free-running count 0..STEP_CYCLES−1, then wraps to 0. Reset value 0.
  - `step_tick` is asserted in the cycle where `step_cnt` == STEP_CYCLES−1.
  - It runs regardless of `fade_en` and input activity.
- `duty[i]` (PWM_BITS wide, reset value 0), evaluated in priority order:
  1. `rst`: set to 0.
  2. `fade_en`=0: load `tgt[i]`.
  3. `step_tick`=1: if `duty` < `tgt`, add 1; if `duty` > `tgt`, subtract 1; otherwise hold.
  4. Otherwise hold.
  - `duty` never over- or underflows; it saturates at 0 and at MAX by construction.
- Target change mid-ramp: the channel reverses direction from its current `duty` on the next `step_tick`. No jump.
- `fade_en` 1→0 mid-ramp: every channel snaps to its target on the next edge.
- `pwm_cnt` (PWM_BITS wide): free-running +1 every cycle, wraps MAX→0. Reset value 0.
- `duty_sh[i]`: shadow of `duty[i]`, loaded only in the cycle where `pwm_cnt` == MAX. Reset value 0.
  - A new duty therefore takes effect at a PWM period boundary, so no period is ever truncated.
- `leds_out[i]` is registered: next value = ~(`pwm_cnt` < `duty_sh[i]`).
  - Duty 0 → constantly 1 (off).
  - Duty MAX → low for MAX of every 2^PWM_BITS cycles.
  - Duty d → low for exactly d cycles per period, starting at `pwm_cnt`=0.
- `busy` = OR over i of (`duty[i]` ≠ `tgt[i]`). Combinational from registers only; reset value 0.
- The three channels are independent and share `pwm_cnt` and `step_tick`.

## Timing
- Notation: `leds_in` changes before edge k, so `in_q` updates at edge k.
- `busy` may rise in the cycle after edge k.
- With `fade_en`=0:
  - `duty` reaches the target at edge k+1, and `busy` falls after edge k+1.
  - `duty_sh` takes the new value at the first edge where `pwm_cnt` == MAX.
  - `leds_out` reflects it starting one edge later, at the edge where `pwm_cnt` goes 0→1.
- With `fade_en`=1:
  - A full ramp 0→MAX takes MAX `step_tick`s, i.e. ≤ MAX·STEP_CYCLES cycles after edge k.
  - The first step occurs at the first `step_tick` after edge k.
- `leds_out` latency relative to `pwm_cnt`/`duty_sh`: 1 cycle.
- Reset asserted mid-operation: all registers return to their reset values at that edge, so `leds_out`=3'b111 and `busy`=0 after the edge.
- Reset deasserted: `pwm_cnt` and `step_cnt` start from 0 on the first non-reset edge.

## Test plan
Bench parameters: `PWM_BITS`=4 (MAX=15), `STEP_CYCLES`=4.
- Reset: hold `rst` for 3 cycles with `leds_in`=3'b000 → `leds_out`=3'b111 and `busy`=0 throughout. After release, the duty of every channel starts at 0.
- Snap: `fade_en`=0, `leds_in` 3'b111→3'b110 → `busy` high for exactly 1 cycle, `duty[0]`=15. From the next period boundary, `leds_out[0]` is low 15 of every 16 cycles; bits 2:1 stay 1.
- Fade up: `fade_en`=1, `leds_in`=3'b101 → `duty[1]` increments by 1 every 4 cycles and reaches 15 within 60 cycles, then `busy` falls. The low-time per 16-cycle period is nondecreasing.
- Reversal: mid-ramp with `duty[1]`=7, set `leds_in`=3'b111 → the next step gives 6 with no jump. `duty[1]` reaches 0 after 7 more steps (28 cycles), then `busy`=0.
- Snap mid-ramp: while fading with `duty[2]`=5 and target 15, drop `fade_en` to 0 → `duty[2]`=15 on the next edge and `busy` deasserts. The shadow updates only at `pwm_cnt`=15.
- Reset mid-fade: assert `rst` for 1 cycle during a ramp → after that edge, `leds_out`=3'b111, `busy`=0, and all duties are 0. `in_q`=3'b111, so targets read 0 until `in_q` re-registers `leds_in`; the ramp toward `leds_in` then restarts from 0.
